mte_stream_engine: RTL and testbench

- Parametrised, streaming MAC-then-Encrypt / verify-then-Decrypt engine.
- Processes a message of BLOCKS words of N bits per operation, through valid/ready handshakes on input and output.
- Encrypt mode emits the ciphertext words followed by an encrypted MAC tag word.
- Decrypt mode buffers the recovered plaintext, checks the tag, and releases plaintext only on a tag match. This replaces the single-word, handshake-free combinational MTE path.

---
 rtl/mte_stream_engine.sv | 183 ++++++++++++++++++
 tb/tb_mte_stream_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mte_stream_engine.sv
// Streaming MAC-then-encrypt / verify-then-decrypt engine over BLOCKS words of N bits.
// Decrypted plaintext is held in an internal buffer and released only after the tag matches.
module mte_stream_engine #(
    parameter int unsigned N      = 8,
    parameter int unsigned BLOCKS = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         auth_ok
);

    localparam int unsigned CW = $clog2(BLOCKS + 1);
    localparam int unsigned IW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCKS - 1);
    localparam logic [N-1:0]  TAG_IDX  = N'(BLOCKS);

    typedef enum logic [2:0] {
        IDLE,
        ENC_DATA,
        ENC_TAG,
        DEC_DATA,
        DEC_TAG,
        DEC_OUT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  key_q;
    logic [N-1:0]  mac;
    logic [N-1:0]  pbuf [BLOCKS];
    logic [N-1:0]  dec_p;
    logic          accept;
    logic          out_free;

    function automatic logic [N-1:0] enc_word(input logic [N-1:0] p, input logic [N-1:0] k,
                                              input logic [N-1:0] i);
        return (p ^ k) + i;
    endfunction

    function automatic logic [N-1:0] dec_word(input logic [N-1:0] c, input logic [N-1:0] k,
                                              input logic [N-1:0] i);
        return (c - i) ^ k;
    endfunction

    function automatic logic [N-1:0] mac_fold(input logic [N-1:0] m, input logic [N-1:0] p);
        return {m[N-2:0], m[N-1]} ^ p;
    endfunction

    // Encrypt input stalls behind a full output register; decrypt input is always taken.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ENC_DATA:         in_ready = !out_valid || out_ready;
            DEC_DATA, DEC_TAG: in_ready = 1'b1;
            default:          in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign dec_p    = dec_word(in_data, key_q, N'(cnt));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_q     <= '0;
            mac       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            auth_ok   <= 1'b0;
            for (int unsigned j = 0; j < BLOCKS; j++) pbuf[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_q   <= key;
                        mac     <= key;
                        cnt     <= '0;
                        auth_ok <= 1'b0;
                        busy    <= 1'b1;
                        state   <= mode ? ENC_DATA : DEC_DATA;
                    end
                end
                ENC_DATA: begin
                    if (accept) begin
                        out_data  <= enc_word(in_data, key_q, N'(cnt));
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        mac       <= mac_fold(mac, in_data);
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= ENC_TAG;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ENC_TAG: begin
                    // out_last marks that the tag already sits in the output register.
                    if (out_valid && out_last) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            auth_ok   <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (out_free) begin
                        out_data  <= enc_word(mac, key_q, TAG_IDX);
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                    end
                end
                DEC_DATA: begin
                    if (accept) begin
                        pbuf[IW'(cnt)] <= dec_p;
                        mac            <= mac_fold(mac, dec_p);
                        if (cnt == LAST_IDX) begin
                            cnt   <= '0;
                            state <= DEC_TAG;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DEC_TAG: begin
                    if (accept) begin
                        if (in_data == enc_word(mac, key_q, TAG_IDX)) begin
                            auth_ok <= 1'b1;
                            state   <= DEC_OUT;
                        end else begin
                            auth_ok <= 1'b0;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                            for (int unsigned j = 0; j < BLOCKS; j++) pbuf[j] <= '0;
                        end
                    end
                end
                DEC_OUT: begin
                    // cnt is reused as the read pointer into the plaintext buffer.
                    if (out_valid && out_last) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            cnt       <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (out_free) begin
                        out_data  <= pbuf[IW'(cnt)];
                        out_valid <= 1'b1;
                        out_last  <= (cnt == LAST_IDX);
                        cnt       <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mte_stream_engine.sv
// Self-checking bench for mte_stream_engine (N=8, BLOCKS=2): vector table, scoreboard of
// expected output words, plus stall, reset-abort and ignored-input sequences.
module tb_mte_stream_engine;

    localparam int unsigned N      = 8;
    localparam int unsigned BLOCKS = 2;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic         mode;
    logic [N-1:0] key;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         auth_ok;

    mte_stream_engine #(.N(N), .BLOCKS(BLOCKS)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .key      (key),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .auth_ok  (auth_ok)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic           mode;
        logic [7:0]     key;
        logic [2:0][7:0] in_w;
        int             n_in;
        logic [2:0][7:0] exp_w;
        int             n_out;
        logic           exp_auth;
        logic           stall;
        logic           poke;
    } tv_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_enc(input logic [7:0] p, input logic [7:0] k, input int i);
        return (p ^ k) + 8'(i);
    endfunction

    function automatic logic [7:0] m_rotl_xor(input logic [7:0] m, input logic [7:0] p);
        return {m[6:0], m[7]} ^ p;
    endfunction

    function automatic tv_t make_tv(input logic md, input logic [7:0] k,
                                    input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                    input int n_in,
                                    input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                    input int n_out, input logic au, input logic st, input logic pk);
        tv_t t;
        t.mode = md; t.key = k;
        t.in_w[0] = a; t.in_w[1] = b; t.in_w[2] = c; t.n_in = n_in;
        t.exp_w[0] = x; t.exp_w[1] = y; t.exp_w[2] = z; t.n_out = n_out;
        t.exp_auth = au; t.stall = st; t.poke = pk;
        return t;
    endfunction

    // Output monitor: scoreboard compare on each handshake, stability while stalled.
    logic       pv, pr, pl;
    logic [7:0] pd;
    initial begin pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; end
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (pv && !pr) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(pd));
                check("stall_last", 32'(out_last), 32'(pl));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h expected none at %0t", out_data, $time);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
            end
            if (done) done_cnt++;
        end
        pv = out_valid && reset_n;
        pr = out_ready;
        pd = out_data;
        pl = out_last;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_word(input logic [7:0] w);
        int  guard;
        logic ok;
        in_valid = 1'b1;
        in_data  = w;
        guard = 0;
        ok = 1'b0;
        while (!ok && guard < 200) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            @(posedge clock);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected handshake for 0x%0h", w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_auth_ok"}, 32'(auth_ok), 32'd0);
    endtask

    task automatic run_op(input tv_t t);
        exp_t e;
        int   base;
        int   guard;
        logic got;
        @(posedge clock);
        #1;
        start = 1'b1;
        mode  = t.mode;
        key   = t.key;
        for (int j = 0; j < t.n_out; j++) begin
            e.data = t.exp_w[j];
            e.last = (j == t.n_out - 1);
            sb.push_back(e);
        end
        base = done_cnt;
        @(posedge clock);
        #1;
        start = 1'b0;
        key   = 8'($urandom);
        for (int j = 0; j < t.n_in; j++) begin
            send_word(t.in_w[j]);
            if (t.stall && j == 0) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = t.in_w[1];
                for (int s = 0; s < 5; s++) begin
                    @(negedge clock);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_word", 32'(out_data), 32'(t.exp_w[0]));
                end
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
            if (t.poke && j == 0) begin
                start = 1'b1;
                mode  = ~t.mode;
                key   = 8'hFF;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
        end
        guard = 0;
        got   = 1'b0;
        while (!got && guard < 100) begin
            @(negedge clock);
            if (done) got = 1'b1;
            guard++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected a pulse");
        end else begin
            check("done_busy", 32'(busy), 32'd0);
            check("auth_ok", 32'(auth_ok), 32'(t.exp_auth));
            @(negedge clock);
            check("done_width", 32'(done), 32'd0);
            check("auth_hold", 32'(auth_ok), 32'(t.exp_auth));
        end
        check("done_count", 32'(done_cnt - base), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    tv_t tv[14];

    initial begin
        logic [7:0] k, p0, p1, c0, c1, m, tag;
        reset_n   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        key       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        tv[0] = make_tv(1'b1, 8'h5A, 8'h12, 8'h34, 8'h00, 2, 8'h48, 8'h6F, 8'h25, 3, 1'b1, 1'b0, 1'b0);
        tv[1] = make_tv(1'b0, 8'h5A, 8'h48, 8'h6F, 8'h25, 3, 8'h12, 8'h34, 8'h00, 2, 1'b1, 1'b0, 1'b0);
        tv[2] = make_tv(1'b0, 8'h5A, 8'h48, 8'h6F, 8'h26, 3, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        tv[3] = make_tv(1'b1, 8'h5A, 8'h12, 8'h34, 8'h00, 2, 8'h48, 8'h6F, 8'h25, 3, 1'b1, 1'b0, 1'b0);
        tv[4] = make_tv(1'b1, 8'h5A, 8'h12, 8'h34, 8'h00, 2, 8'h48, 8'h6F, 8'h25, 3, 1'b1, 1'b1, 1'b0);
        tv[5] = make_tv(1'b1, 8'h5A, 8'h12, 8'h34, 8'h00, 2, 8'h48, 8'h6F, 8'h25, 3, 1'b1, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            k   = 8'($urandom);
            p0  = 8'($urandom);
            p1  = 8'($urandom);
            c0  = m_enc(p0, k, 0);
            c1  = m_enc(p1, k, 1);
            m   = m_rotl_xor(m_rotl_xor(k, p0), p1);
            tag = m_enc(m, k, 2);
            tv[6 + 2*r] = make_tv(1'b1, k, p0, p1, 8'h00, 2, c0, c1, tag, 3, 1'b1, 1'b0, 1'b0);
            if (r == 3)
                tv[7 + 2*r] = make_tv(1'b0, k, c0, c1, tag ^ 8'h80, 3, 8'h00, 8'h00, 8'h00, 0,
                                      1'b0, 1'b0, 1'b0);
            else
                tv[7 + 2*r] = make_tv(1'b0, k, c0, c1, tag, 3, p0, p1, 8'h00, 2, 1'b1, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clock);
        check_reset_outputs("por");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) run_op(tv[i]);

        // Abort a decrypt after its first word; no done may follow.
        begin
            int base;
            @(posedge clock);
            #1;
            start = 1'b1; mode = 1'b0; key = 8'h5A;
            @(posedge clock);
            #1;
            start = 1'b0;
            send_word(8'h48);
            base = done_cnt;
            reset_n = 1'b0;
            @(negedge clock);
            check_reset_outputs("abort");
            repeat (2) @(posedge clock);
            #1;
            reset_n = 1'b1;
            repeat (5) @(negedge clock);
            check("abort_no_done", 32'(done_cnt - base), 32'd0);
            check("abort_idle_busy", 32'(busy), 32'd0);
        end
        run_op(tv[0]);

        // in_valid while idle must not be taken.
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        run_op(tv[1]);
        run_op(tv[0]);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
